bus_transfer_controller: RTL and testbench

- Bus initiator for the shared 8-bit register data bus.
- Accepts transfer commands over a valid/ready handshake and sequences the per-register output-enable and write-enable strobes.
- Supports three operations: register-to-register moves, immediate loads driven by the controller, and readback of a register into the controller.
- Sits between the instruction decode/sequencer and the bank of bus registers; it is the only block allowed to assert register oe/wr strobes.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_strobe_decoder.sv | 47 ++++
 rtl/bus_transfer_controller.sv | 139 +++++++++++++
 tb/tb_bus_transfer_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the register data bus controller.
package bus_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP_MOVE     = 2'd0,
    OP_LOAD_IMM = 2'd1,
    OP_READ     = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/bus_strobe_decoder.sv
// Maps (state, op, src, dst) to register strobes and the controller bus drive enable.
module bus_strobe_decoder
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  state_e              state_i,
  input  logic [1:0]          op_i,
  input  logic [SEL_W-1:0]    src_i,
  input  logic [SEL_W-1:0]    dst_i,
  output logic [NUM_REGS-1:0] oe_c,
  output logic [NUM_REGS-1:0] wr_c,
  output logic                drive_c
);

  always_comb begin
    oe_c    = '0;
    wr_c    = '0;
    drive_c = 1'b0;
    case (state_i)
      SETUP: begin
        case (op_i)
          OP_MOVE, OP_READ: oe_c[src_i] = 1'b1;
          OP_LOAD_IMM:      drive_c     = 1'b1;
          default: ;
        endcase
      end
      COMMIT: begin
        case (op_i)
          OP_MOVE: begin
            oe_c[src_i] = 1'b1;
            wr_c[dst_i] = 1'b1;
          end
          OP_LOAD_IMM: begin
            drive_c     = 1'b1;
            wr_c[dst_i] = 1'b1;
          end
          OP_READ: oe_c[src_i] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_transfer_controller.sv
// Bus initiator: accepts MOVE / LOAD_IMM / READ commands and sequences register oe/wr strobes.
module bus_transfer_controller
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SEL_W-1:0]    req_src,
  input  logic [SEL_W-1:0]    req_dst,
  input  logic [DATA_W-1:0]   req_imm,
  inout  wire  [DATA_W-1:0]   dataBus,
  output logic [NUM_REGS-1:0] reg_oe,
  output logic [NUM_REGS-1:0] reg_wr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                done,
  output logic                err,
  output logic                busy
);

  localparam int unsigned      SEL_X_W   = SEL_W + 1;
  localparam logic [SEL_X_W-1:0] REG_LIMIT = SEL_X_W'(NUM_REGS);

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [SEL_W-1:0]    src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0]   imm_q, imm_d, rd_data_q, rd_data_d;
  logic                done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [NUM_REGS-1:0] reg_oe_q, reg_wr_q, oe_c, wr_c;
  logic                drive_q, drive_c;
  logic                src_bad_c, dst_bad_c, illegal_c;

  // Command legality, evaluated on the live request at accept time.
  always_comb begin
    src_bad_c = ({1'b0, req_src} >= REG_LIMIT);
    dst_bad_c = ({1'b0, req_dst} >= REG_LIMIT);
    case (req_op)
      OP_MOVE:     illegal_c = src_bad_c | dst_bad_c | (req_src == req_dst);
      OP_LOAD_IMM: illegal_c = dst_bad_c;
      OP_READ:     illegal_c = src_bad_c;
      default:     illegal_c = 1'b1;
    endcase
  end

  // Next-state and captures; everything holds while clk_en is low.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    imm_d     = imm_q;
    rd_data_d = rd_data_q;
    done_d    = done_q;
    err_d     = err_q;
    if (clk_en) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_d  = req_op;
            src_d = req_src;
            dst_d = req_dst;
            imm_d = req_imm;
            if (illegal_c) err_d   = 1'b1;
            else           state_d = SETUP;
          end
        end
        SETUP:  state_d = COMMIT;
        COMMIT: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (op_q == OP_READ) rd_data_d = dataBus;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  bus_strobe_decoder #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_decoder (
    .state_i (state_d),
    .op_i    (op_d),
    .src_i   (src_d),
    .dst_i   (dst_d),
    .oe_c    (oe_c),
    .wr_c    (wr_c),
    .drive_c (drive_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 2'd0;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      reg_oe_q  <= '0;
      reg_wr_q  <= '0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      imm_q     <= imm_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      reg_oe_q  <= oe_c;
      reg_wr_q  <= wr_c;
      drive_q   <= drive_c;
    end
  end

  assign req_ready = (state_q == IDLE) && rst_n;
  assign dataBus   = drive_q ? imm_q : {DATA_W{1'bz}};
  assign reg_oe    = reg_oe_q;
  assign reg_wr    = reg_wr_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed bench for bus_transfer_controller with a behavioural register bank on the bus.
module tb_bus_transfer_controller;

  localparam logic [1:0] OPC_MOVE = 2'd0;
  localparam logic [1:0] OPC_LOAD = 2'd1;
  localparam logic [1:0] OPC_READ = 2'd2;
  localparam logic [1:0] OPC_RSV  = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [2:0] req_src = 3'd0;
  logic [2:0] req_dst = 3'd0;
  logic [7:0] req_imm = 8'h00;
  wire  [7:0] data_bus;
  wire        req_ready, done, err, busy;
  wire  [7:0] reg_oe, reg_wr, rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] regs [8];
  logic       bank_clr = 1'b1;
  logic [7:0] bank_val;
  logic       bank_en;

  always #5 clk = ~clk;

  bus_transfer_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_imm   (req_imm),
    .dataBus   (data_bus),
    .reg_oe    (reg_oe),
    .reg_wr    (reg_wr),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  // Undriven bus reads as FF so "controller not driving" is observable.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bank_clr) regs[i] <= 8'h00;
      else if (clk_en && reg_wr[i]) regs[i] <= data_bus;
    end
  end

  always_comb begin
    bank_val = 8'h00;
    bank_en  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (reg_oe[i]) begin
        bank_en  = 1'b1;
        bank_val = regs[i];
      end
    end
  end

  assign data_bus = bank_en ? bank_val : 8'hzz;

  // Bus invariants, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(reg_oe) > 1) begin errors++; $display("FAIL inv_oe_onehot got %b", reg_oe); end
      if ($countones(reg_wr) > 1) begin errors++; $display("FAIL inv_wr_onehot got %b", reg_wr); end
      if ((reg_oe & reg_wr) != 8'h00) begin errors++; $display("FAIL inv_oe_wr_overlap oe %b wr %b", reg_oe, reg_wr); end
      if (bank_en && data_bus !== bank_val) begin errors++; $display("FAIL inv_bus_contention got %h want %h", data_bus, bank_val); end
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst, input logic [7:0] imm);
    req_valid = 1'b1;
    req_op    = op;
    req_src   = src;
    req_dst   = dst;
    req_imm   = imm;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (reg_oe !== 8'h00) begin errors++; $display("FAIL rst_oe got %h want 00", reg_oe); end
    checks++; if (reg_wr !== 8'h00) begin errors++; $display("FAIL rst_wr got %h want 00", reg_wr); end
    checks++; if (data_bus !== 8'hFF) begin errors++; $display("FAIL rst_bus_z got %h want FF(pulled)", data_bus); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", rd_data); end
    checks++; if ({busy, done, err, req_ready} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {busy, done, err, req_ready}); end
    bank_clr = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
  endtask

  task automatic test_move();
    drive_cmd(OPC_LOAD, 3'd0, 3'd2, 8'hA5);
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    drive_cmd(OPC_MOVE, 3'd2, 3'd5, 8'h00);
    @(negedge clk);
    req_valid = 1'b0; req_src = 3'd6; req_dst = 3'd0;
    checks++; if (reg_oe !== 8'b0000_0100) begin errors++; $display("FAIL move_oe_setup got %b want 00000100", reg_oe); end
    checks++; if (reg_wr !== 8'h00) begin errors++; $display("FAIL move_wr_setup got %b want 0", reg_wr); end
    checks++; if ({busy, req_ready} !== 2'b10) begin errors++; $display("FAIL move_busy got %b want 10", {busy, req_ready}); end
    @(negedge clk);
    checks++; if (reg_oe !== 8'b0000_0100) begin errors++; $display("FAIL move_oe_commit got %b want 00000100", reg_oe); end
    checks++; if (reg_wr !== 8'b0010_0000) begin errors++; $display("FAIL move_wr_commit got %b want 00100000", reg_wr); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL move_done got %b want 1", done); end
    checks++; if ({reg_oe, reg_wr} !== 16'h0000) begin errors++; $display("FAIL move_strobes_idle got %h want 0000", {reg_oe, reg_wr}); end
    checks++; if (regs[5] !== 8'hA5) begin errors++; $display("FAIL move_reg5 got %h want A5", regs[5]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL move_done_pulse got %b want 0", done); end
  endtask

  task automatic test_load_read();
    drive_cmd(OPC_LOAD, 3'd0, 3'd7, 8'h3C);
    @(negedge clk); req_valid = 1'b0;
    checks++; if (data_bus !== 8'h3C) begin errors++; $display("FAIL load_bus_setup got %h want 3C", data_bus); end
    checks++; if ({reg_oe, reg_wr} !== 16'h0000) begin errors++; $display("FAIL load_strobes_setup got %h want 0000", {reg_oe, reg_wr}); end
    @(negedge clk);
    checks++; if (reg_wr !== 8'h80) begin errors++; $display("FAIL load_wr_commit got %b want 10000000", reg_wr); end
    checks++; if (data_bus !== 8'h3C) begin errors++; $display("FAIL load_bus_commit got %h want 3C", data_bus); end
    @(negedge clk);
    checks++; if ({done, req_ready} !== 2'b11) begin errors++; $display("FAIL load_done_ready got %b want 11", {done, req_ready}); end
    checks++; if (regs[7] !== 8'h3C) begin errors++; $display("FAIL load_reg7 got %h want 3C", regs[7]); end
    checks++; if (data_bus !== 8'hFF) begin errors++; $display("FAIL load_bus_release got %h want FF(pulled)", data_bus); end
    drive_cmd(OPC_READ, 3'd7, 3'd0, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    checks++; if (reg_oe !== 8'h80) begin errors++; $display("FAIL read_oe_setup got %b want 10000000", reg_oe); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL read_done_early got %b want 0", done); end
    @(negedge clk);
    checks++; if ({reg_oe, reg_wr} !== 16'h8000) begin errors++; $display("FAIL read_strobes_commit got %h want 8000", {reg_oe, reg_wr}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL read_done got %b want 1", done); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL read_rd_data got %h want 3C", rd_data); end
  endtask

  task automatic test_illegal();
    drive_cmd(OPC_MOVE, 3'd4, 3'd4, 8'h00);
    @(negedge clk);
    checks++; if ({err, busy, req_ready} !== 3'b101) begin errors++; $display("FAIL ill_move_flags got %b want 101", {err, busy, req_ready}); end
    checks++; if ({reg_oe, reg_wr} !== 16'h0000) begin errors++; $display("FAIL ill_move_strobes got %h want 0000", {reg_oe, reg_wr}); end
    checks++; if (data_bus !== 8'hFF) begin errors++; $display("FAIL ill_move_bus got %h want FF(pulled)", data_bus); end
    drive_cmd(OPC_RSV, 3'd1, 3'd2, 8'h55);
    @(negedge clk); req_valid = 1'b0;
    checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL ill_op3_flags got %b want 10", {err, busy}); end
    checks++; if (data_bus !== 8'hFF) begin errors++; $display("FAIL ill_op3_bus got %h want FF(pulled)", data_bus); end
    @(negedge clk);
    checks++; if ({err, done} !== 2'b00) begin errors++; $display("FAIL ill_err_pulse got %b want 00", {err, done}); end
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL ill_rd_data got %h want 3C", rd_data); end
  endtask

  task automatic test_stall();
    drive_cmd(OPC_MOVE, 3'd7, 3'd1, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({reg_oe, reg_wr} !== 16'h8000) begin errors++; $display("FAIL stall_strobes_%0d got %h want 8000", i, {reg_oe, reg_wr}); end
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL stall_flags_%0d got %b want 10", i, {busy, done}); end
    end
    clk_en = 1'b1;
    @(negedge clk);
    checks++; if ({reg_oe, reg_wr} !== 16'h8002) begin errors++; $display("FAIL stall_commit got %h want 8002", {reg_oe, reg_wr}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
    checks++; if (regs[1] !== 8'h3C) begin errors++; $display("FAIL stall_reg1 got %h want 3C", regs[1]); end
    clk_en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done_stretch got %b want 1", done); end
    clk_en = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_clear got %b want 0", done); end
  endtask

  task automatic test_reset_commit();
    drive_cmd(OPC_MOVE, 3'd1, 3'd3, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if (reg_wr !== 8'h08) begin errors++; $display("FAIL rstc_wr_commit got %b want 00001000", reg_wr); end
    rst_n = 1'b0;
    #1;
    checks++; if ({reg_oe, reg_wr} !== 16'h0000) begin errors++; $display("FAIL rstc_strobes_drop got %h want 0000", {reg_oe, reg_wr}); end
    checks++; if ({busy, req_ready} !== 2'b00) begin errors++; $display("FAIL rstc_flags got %b want 00", {busy, req_ready}); end
    @(negedge clk);
    checks++; if (regs[3] !== 8'h00) begin errors++; $display("FAIL rstc_reg3 got %h want 00", regs[3]); end
    checks++; if ({done, rd_data} !== 9'h000) begin errors++; $display("FAIL rstc_done_rd got %h want 000", {done, rd_data}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({req_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL rstc_release got %b want 100", {req_ready, busy, done}); end
    checks++; if (regs[3] !== 8'h00) begin errors++; $display("FAIL rstc_reg3_after got %h want 00", regs[3]); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_load_read();
    test_illegal();
    test_stall();
    test_reset_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
